dm_waitstate_bytelane: RTL and testbench

Parametrised data memory for the pipelined MIPS CPU. Replaces the single-cycle word-only DM. Supports byte, halfword and word loads and stores (sb/sh/sw, lb/lbu/lh/lhu) with sign or zero extension. Requests use a valid/busy handshake with a configurable wait-state count, so the MEM stage can stall. A per-store trace port feeds the testbench logger.

---
 rtl/dm_pkg.sv | 20 ++
 rtl/dm_lane_align.sv | 76 +++++++
 rtl/dm_waitstate_bytelane.sv | 205 ++++++++++++++++++++
 tb/tb_dm_waitstate_bytelane.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// dm_pkg: shared definitions for the wait-state data memory.
//   - req_op encodings for word / half / byte accesses
//   - FSM state type for the access controller
//   - wait-state counter width (WAIT may range 0..15)
package dm_pkg;

    localparam logic [2:0] OP_W  = 3'd0;  // word
    localparam logic [2:0] OP_HS = 3'd1;  // half, sign-extended
    localparam logic [2:0] OP_HU = 3'd2;  // half, zero-extended
    localparam logic [2:0] OP_BS = 3'd3;  // byte, sign-extended
    localparam logic [2:0] OP_BU = 3'd4;  // byte, zero-extended

    localparam int CNT_W = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/dm_lane_align.sv
// dm_lane_align: purely combinational byte-lane steering for a 32-bit
// little-endian word memory. Shared between the data memory and any
// future cache that needs the same sub-word semantics.
//
// Ports:
//   op          in  3   access size / extension (dm_pkg OP_* codes)
//   addr_lo     in  2   byte offset within the word
//   old_word    in  32  current contents of the addressed word
//   wdata       in  32  store data (low byte/half used for sub-word stores)
//   merged_word out 32  old_word with the addressed lanes replaced
//   load_word   out 32  extracted and extended load result
//   err         out 1   illegal op or misaligned address
module dm_lane_align
    import dm_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] merged_word,
    output logic [31:0] load_word,
    output logic        err
);

    logic [3:0]  byte_en;
    logic [31:0] store_lanes;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        byte_en     = 4'b0000;
        store_lanes = wdata;
        err         = 1'b0;
        load_word   = old_word;

        case (addr_lo)
            2'd0:    sel_byte = old_word[7:0];
            2'd1:    sel_byte = old_word[15:8];
            2'd2:    sel_byte = old_word[23:16];
            default: sel_byte = old_word[31:24];
        endcase
        sel_half = addr_lo[1] ? old_word[31:16] : old_word[15:0];

        case (op)
            OP_W: begin
                err         = (addr_lo != 2'd0);
                byte_en     = 4'b1111;
                store_lanes = wdata;
                load_word   = old_word;
            end
            OP_HS, OP_HU: begin
                err         = addr_lo[0];
                byte_en     = addr_lo[1] ? 4'b1100 : 4'b0011;
                // Replicate so whichever half is enabled picks up wdata[15:0].
                store_lanes = {2{wdata[15:0]}};
                load_word   = (op == OP_HS) ? {{16{sel_half[15]}}, sel_half}
                                            : {16'h0000, sel_half};
            end
            OP_BS, OP_BU: begin
                byte_en     = 4'b0001 << addr_lo;
                store_lanes = {4{wdata[7:0]}};
                load_word   = (op == OP_BS) ? {{24{sel_byte[7]}}, sel_byte}
                                            : {24'h000000, sel_byte};
            end
            default: begin
                err = 1'b1;
            end
        endcase
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign merged_word[8*gi +: 8] = byte_en[gi] ? store_lanes[8*gi +: 8]
                                                    : old_word[8*gi +: 8];
    end

endmodule

// File: rtl/dm_waitstate_bytelane.sv
// dm_waitstate_bytelane: data memory for the pipelined MIPS core with
// byte/half/word access, sign/zero extension, a valid/busy handshake with
// WAIT extra busy cycles per access, and a per-store trace port.
//
// Ports:
//   clk, reset                 clock / synchronous active-high reset
//   req_valid, req_we, req_op  request handshake, store flag, access kind
//   req_addr, req_wdata        byte address, store data
//   req_pc                     issuing PC (trace only)
//   busy                       access in flight (combinational from state)
//   rdata_valid, rdata         load completion pulse and held result
//   addr_err                   misaligned / illegal-op completion pulse
//   wr_trace_*                 committed-store pulse, pc, aligned addr, word
module dm_waitstate_bytelane
    import dm_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int IDX_W       = $clog2(DEPTH_WORDS),
    parameter int WAIT        = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        busy,
    output logic        rdata_valid,
    output logic [31:0] rdata,
    output logic        addr_err,
    output logic        wr_trace_valid,
    output logic [31:0] wr_trace_pc,
    output logic [31:0] wr_trace_addr,
    output logic [31:0] wr_trace_data
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [2:0]         op_q, op_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        pc_q, pc_d;

    logic               rdata_valid_q, rdata_valid_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               addr_err_q, addr_err_d;
    logic               trace_valid_q, trace_valid_d;
    logic [31:0]        trace_pc_q, trace_pc_d;
    logic [31:0]        trace_addr_q, trace_addr_d;
    logic [31:0]        trace_data_q, trace_data_d;

    logic [31:0]        mem_q [DEPTH_WORDS];
    logic [IDX_W-1:0]   mem_idx;
    logic [31:0]        mem_rd;
    logic               mem_we;

    logic [31:0]        merged_word;
    logic [31:0]        load_word;
    logic               lane_err;

    logic               accept;
    logic               complete;

    assign accept   = (state_q == ST_IDLE) && req_valid;
    assign complete = (state_q == ST_BUSY) && (cnt_q == '0);

    // Upper address bits are deliberately dropped: accesses wrap.
    assign mem_idx  = addr_q[IDX_W+1:2];
    // Asynchronous read of the latched index; memory cannot change between
    // accept and completion because only one access is ever in flight.
    assign mem_rd   = mem_q[mem_idx];

    dm_lane_align u_lane_align (
        .op          (op_q),
        .addr_lo     (addr_q[1:0]),
        .old_word    (mem_rd),
        .wdata       (wdata_q),
        .merged_word (merged_word),
        .load_word   (load_word),
        .err         (lane_err)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)   state_d = ST_BUSY;
            ST_BUSY: if (complete) state_d = ST_IDLE;
            default:               state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy = (state_q == ST_BUSY);
    end

    // ---------------- datapath next values ----------------
    always_comb begin
        cnt_d         = cnt_q;
        we_d          = we_q;
        op_d          = op_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        pc_d          = pc_q;
        rdata_valid_d = 1'b0;
        rdata_d       = rdata_q;
        addr_err_d    = 1'b0;
        trace_valid_d = 1'b0;
        trace_pc_d    = trace_pc_q;
        trace_addr_d  = trace_addr_q;
        trace_data_d  = trace_data_q;
        mem_we        = 1'b0;

        if (accept) begin
            we_d    = req_we;
            op_d    = req_op;
            addr_d  = req_addr;
            wdata_d = req_wdata;
            pc_d    = req_pc;
            cnt_d   = CNT_W'(WAIT);
        end else if (state_q == ST_BUSY) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else if (lane_err) begin
                addr_err_d = 1'b1;
            end else if (we_q) begin
                mem_we        = 1'b1;
                trace_valid_d = 1'b1;
                trace_pc_d    = pc_q;
                trace_addr_d  = {addr_q[31:2], 2'b00};
                trace_data_d  = merged_word;
            end else begin
                rdata_valid_d = 1'b1;
                rdata_d       = load_word;
            end
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q         <= '0;
            we_q          <= 1'b0;
            op_q          <= 3'd0;
            addr_q        <= '0;
            wdata_q       <= '0;
            pc_q          <= '0;
            rdata_valid_q <= 1'b0;
            rdata_q       <= '0;
            addr_err_q    <= 1'b0;
            trace_valid_q <= 1'b0;
            trace_pc_q    <= '0;
            trace_addr_q  <= '0;
            trace_data_q  <= '0;
        end else begin
            cnt_q         <= cnt_d;
            we_q          <= we_d;
            op_q          <= op_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            pc_q          <= pc_d;
            rdata_valid_q <= rdata_valid_d;
            rdata_q       <= rdata_d;
            addr_err_q    <= addr_err_d;
            trace_valid_q <= trace_valid_d;
            trace_pc_q    <= trace_pc_d;
            trace_addr_q  <= trace_addr_d;
            trace_data_q  <= trace_data_d;
        end
    end

    // ---------------- memory array ----------------
    // Reset clears every word so simulation starts from a known image.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[mem_idx] <= merged_word;
        end
    end

    assign rdata_valid    = rdata_valid_q;
    assign rdata          = rdata_q;
    assign addr_err       = addr_err_q;
    assign wr_trace_valid = trace_valid_q;
    assign wr_trace_pc    = trace_pc_q;
    assign wr_trace_addr  = trace_addr_q;
    assign wr_trace_data  = trace_data_q;

endmodule

// File: tb/tb_dm_waitstate_bytelane.sv
// Scoreboard bench: two DUT instances (WAIT=2 and WAIT=0, both 4096 words).
// Stimulus pushes expected completions computed from a byte-addressed
// reference memory; a per-instance monitor pops and compares on each pulse.
module tb_dm_waitstate_bytelane;

    localparam int NBYTES = 4096 * 4;
    localparam int KL = 0;  // load completion
    localparam int KS = 1;  // store completion
    localparam int KE = 2;  // address / op error

    typedef struct {
        int          kind;
        logic [31:0] a;  // load: rdata   store: pc
        logic [31:0] b;  // store: aligned address
        logic [31:0] c;  // store: merged word
    } exp_t;

    logic        clk;
    logic [1:0]  rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_we;
    logic [2:0]  req_op    [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [31:0] req_pc    [2];
    logic [1:0]  busy;
    logic [1:0]  rdata_valid;
    logic [31:0] rdata     [2];
    logic [1:0]  addr_err;
    logic [1:0]  tr_valid;
    logic [31:0] tr_pc     [2];
    logic [31:0] tr_addr   [2];
    logic [31:0] tr_data   [2];

    int          errors = 0;
    int          checks = 0;
    exp_t        exp_q [2][$];
    logic [7:0]  ref_mem [2][NBYTES];
    logic [31:0] last_rdata [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input int d, input string name, input logic [31:0] act,
                       input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s dut%0d: got %h want %h", name, d, act, want);
        end
    endtask

    task automatic model_clear(input int d);
        for (int i = 0; i < NBYTES; i++) ref_mem[d][i] = 8'h00;
        last_rdata[d] = 32'h0;
        exp_q[d].delete();
    endtask

    // Reference: memory as a flat byte array, accesses as byte sequences.
    function automatic exp_t model(input int d, input bit we, input bit [2:0] op,
                                   input bit [31:0] addr, input bit [31:0] wdata,
                                   input bit [31:0] pc);
        exp_t e;
        int size, base, wb;
        logic [31:0] v;
        size = (op == 0) ? 4 : (op <= 2) ? 2 : 1;
        base = int'(addr % NBYTES);
        e.a = 0; e.b = 0; e.c = 0;
        if (op > 4 || (addr % size) != 0) begin
            e.kind = KE;
        end else if (we) begin
            for (int k = 0; k < size; k++) ref_mem[d][base + k] = wdata[8*k +: 8];
            wb = base - (base % 4);
            e.kind = KS;
            e.a = pc;
            e.b = addr - (addr % 4);
            e.c = {ref_mem[d][wb+3], ref_mem[d][wb+2], ref_mem[d][wb+1], ref_mem[d][wb]};
        end else begin
            v = 0;
            for (int k = 0; k < size; k++) v = v | (32'(ref_mem[d][base + k]) << (8*k));
            if (op == 1 && v[15]) v = v | 32'hFFFF_0000;
            if (op == 3 && v[7])  v = v | 32'hFFFF_FF00;
            e.kind = KL;
            e.a = v;
        end
        return e;
    endfunction

    task automatic mon(input int d);
        exp_t e;
        logic [2:0] got, want;
        if (rst[d]) return;
        got = {rdata_valid[d], addr_err[d], tr_valid[d]};
        if (got != 3'b000) begin
            if (exp_q[d].size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse dut%0d: got %b want none", d, got);
            end else begin
                e = exp_q[d].pop_front();
                want = (e.kind == KL) ? 3'b100 : (e.kind == KE) ? 3'b010 : 3'b001;
                chk(d, "pulse_kind", 32'(got), 32'(want));
                if (e.kind == KL) begin
                    chk(d, "rdata", rdata[d], e.a);
                    last_rdata[d] = e.a;
                end else begin
                    chk(d, "rdata_hold", rdata[d], last_rdata[d]);
                    if (e.kind == KS) begin
                        chk(d, "trace_pc", tr_pc[d], e.a);
                        chk(d, "trace_addr", tr_addr[d], e.b);
                        chk(d, "trace_data", tr_data[d], e.c);
                    end
                end
            end
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        dm_waitstate_bytelane #(
            .DEPTH_WORDS (4096),
            .IDX_W       (12),
            .WAIT        ((gi == 0) ? 2 : 0)
        ) u_dut (
            .clk            (clk),
            .reset          (rst[gi]),
            .req_valid      (req_valid[gi]),
            .req_we         (req_we[gi]),
            .req_op         (req_op[gi]),
            .req_addr       (req_addr[gi]),
            .req_wdata      (req_wdata[gi]),
            .req_pc         (req_pc[gi]),
            .busy           (busy[gi]),
            .rdata_valid    (rdata_valid[gi]),
            .rdata          (rdata[gi]),
            .addr_err       (addr_err[gi]),
            .wr_trace_valid (tr_valid[gi]),
            .wr_trace_pc    (tr_pc[gi]),
            .wr_trace_addr  (tr_addr[gi]),
            .wr_trace_data  (tr_data[gi])
        );

        always @(negedge clk) mon(gi);
    end

    // Called at a negedge with the DUT idle; returns at a negedge with it idle.
    task automatic issue(input int d, input bit we, input bit [2:0] op,
                         input bit [31:0] addr, input bit [31:0] wdata,
                         input bit [31:0] pc);
        int n;
        exp_q[d].push_back(model(d, we, op, addr, wdata, pc));
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_op[d]    = op;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_pc[d]    = pc;
        @(posedge clk);
        #1;
        // Garbage requests while busy must be ignored.
        req_we[d]    = 1'b1;
        req_op[d]    = 3'($urandom_range(0, 7));
        req_addr[d]  = $urandom();
        req_wdata[d] = $urandom();
        req_pc[d]    = $urandom();
        n = 0;
        @(negedge clk);
        while (busy[d] && n < 40) begin
            n++;
            @(negedge clk);
        end
        req_valid[d] = 1'b0;
        chk(d, "busy_cycles", 32'(n), (d == 0) ? 32'd3 : 32'd1);
        $display("dut%0d %s op=%0d addr=%h wdata=%h pc=%h busy=%0d",
                 d, we ? "ST" : "LD", op, addr, wdata, pc, n);
    endtask

    task automatic check_reset_outputs(input int d);
        chk(d, "rst_busy", 32'(busy[d]), 32'd0);
        chk(d, "rst_rvalid", 32'(rdata_valid[d]), 32'd0);
        chk(d, "rst_rdata", rdata[d], 32'd0);
        chk(d, "rst_err", 32'(addr_err[d]), 32'd0);
        chk(d, "rst_tvalid", 32'(tr_valid[d]), 32'd0);
        chk(d, "rst_tpc", tr_pc[d], 32'd0);
        chk(d, "rst_taddr", tr_addr[d], 32'd0);
        chk(d, "rst_tdata", tr_data[d], 32'd0);
    endtask

    initial begin
        rst       = 2'b11;
        req_valid = 2'b00;
        req_we    = 2'b00;
        for (int d = 0; d < 2; d++) begin
            req_op[d] = 3'd0; req_addr[d] = 0; req_wdata[d] = 0; req_pc[d] = 0;
            model_clear(d);
        end
        repeat (3) @(posedge clk);
        #1 rst = 2'b00;
        @(negedge clk);
        check_reset_outputs(0);
        check_reset_outputs(1);

        // Directed sequence, WAIT=2 instance.
        issue(0, 1, 3'd0, 32'h10, 32'h1234_5678, 32'h400);
        issue(0, 0, 3'd0, 32'h10, 32'h0, 32'h404);
        issue(0, 1, 3'd3, 32'h11, 32'h0000_00AA, 32'h408);
        issue(0, 0, 3'd3, 32'h11, 32'h0, 32'h40C);
        issue(0, 0, 3'd4, 32'h11, 32'h0, 32'h410);
        issue(0, 1, 3'd1, 32'h12, 32'h0000_8001, 32'h414);
        issue(0, 0, 3'd1, 32'h12, 32'h0, 32'h418);
        issue(0, 0, 3'd2, 32'h12, 32'h0, 32'h41C);
        issue(0, 0, 3'd0, 32'h13, 32'h0, 32'h420);
        issue(0, 1, 3'd1, 32'h11, 32'hFFFF_FFFF, 32'h424);
        issue(0, 1, 3'd6, 32'h14, 32'h5555_5555, 32'h428);
        issue(0, 0, 3'd0, 32'h10, 32'h0, 32'h42C);

        // Reset in the middle of a store: nothing may commit.
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_op[0] = 3'd0;
        req_addr[0] = 32'h20; req_wdata[0] = 32'hDEAD_BEEF; req_pc[0] = 32'h500;
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        @(negedge clk);
        chk(0, "busy_before_abort", 32'(busy[0]), 32'd1);
        rst[0] = 1'b1;
        model_clear(0);
        @(posedge clk);
        #1 rst[0] = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk(0, "abort_no_trace", 32'(tr_valid[0]), 32'd0);
        end
        chk(0, "abort_idle", 32'(busy[0]), 32'd0);
        issue(0, 0, 3'd0, 32'h20, 32'h0, 32'h504);
        issue(0, 0, 3'd0, 32'h10, 32'h0, 32'h508);

        // WAIT=0 instance: back-to-back with address wrap.
        issue(1, 1, 3'd0, 32'h0, 32'hCAFE_F00D, 32'h600);
        issue(1, 0, 3'd0, 32'h4000, 32'h0, 32'h604);
        issue(1, 0, 3'd3, 32'h4003, 32'h0, 32'h608);

        // Randomized traffic on a small, aliased window of both instances.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 150; i++) begin
                issue(d, 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7))
                                                  : 3'($urandom_range(0, 4)),
                      $urandom() & 32'hFFFF_C03F, $urandom(), $urandom());
            end
        end

        repeat (4) @(negedge clk);
        chk(0, "queue_drained", 32'(exp_q[0].size()), 32'd0);
        chk(1, "queue_drained", 32'(exp_q[1].size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
